// File: rtl/mfp_ahb_wifi_rx.sv
// mfp_ahb_wifi_rx
//   AHB-Lite slave that deserialises the ESP8266 byte stream on WIFI_RX
//   (8N1, LSB first) into a DEPTH-entry FIFO. A level interrupt fires when
//   the fill level reaches a programmable threshold.
//
//   Optional build macro: MFP_WIFI_RX_PARITY_EN adds one even-parity bit
//   between the data and stop bits (11-bit frame) and enables par_err.
//
// Ports
//   HCLK, HRESETn          clock, async active-low reset
//   HSEL/HADDR/HTRANS/
//   HWRITE/HWDATA          AHB-Lite address/data phase inputs
//   HRDATA, HREADY         read data (combinational in data phase), always ready
//   WIFI_RX                asynchronous serial input, idle high
//   IO_WIFI_INT            registered level interrupt
//
// Register map (word offsets)
//   0x0 DATA   : {23'b0, valid, byte}, reading a non-empty FIFO pops it
//   0x4 STATUS : {15'b0, count[8:0], 3'b0, par_err, overrun, frame_err, full, empty}
//   0x8 CTRL   : [8:0] threshold; write [31] clears errors, [30] flushes
//   0xC        : reads 0
module mfp_ahb_wifi_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH      = 16,
    parameter int THRESH_RST = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [3:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    input  logic        WIFI_RX,
    output logic        IO_WIFI_INT
);
    localparam int          DIV     = CLK_HZ / BAUD;
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

`ifdef MFP_WIFI_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------- serial receiver ----------------
    logic [1:0]  sync_q;
    logic        rx_s, rx_d_q, fall;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        pb_q, pb_d;          // parity mismatch seen in this frame
    logic        rx_push, ferr_set, perr_set;

    assign rx_s = sync_q[1];
    assign fall = rx_d_q & ~rx_s;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q  <= 2'b11;
            rx_d_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            pb_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], WIFI_RX};
            rx_d_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            pb_q    <= pb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        bit_d    = bit_q;
        sh_d     = sh_q;
        pb_d     = pb_q;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                    pb_d    = 1'b0;
                end
            end
            START: if (cnt_q == HALF_M1) begin
                // mid start bit: a high sample means the edge was a glitch
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == DIV_M1) begin
                cnt_d = '0;
                sh_d  = {rx_s, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
`ifdef MFP_WIFI_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef MFP_WIFI_RX_PARITY_EN
            PARITY: if (cnt_q == DIV_M1) begin
                cnt_d   = '0;
                state_d = STOP;
                if (rx_s != ^sh_q) begin
                    pb_d     = 1'b1;
                    perr_set = 1'b1;
                end
            end
`endif
            STOP: if (cnt_q == DIV_M1) begin
                state_d = IDLE;
                if (rx_s) rx_push  = ~pb_q;
                else      ferr_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- AHB-Lite front end ----------------
    logic       dp_vld_q, dp_wr_q;
    logic [1:0] dp_addr_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_vld_q  <= 1'b0;
            dp_wr_q   <= 1'b0;
            dp_addr_q <= '0;
        end else begin
            dp_vld_q  <= HSEL & HTRANS[1];
            dp_wr_q   <= HWRITE;
            dp_addr_q <= HADDR[3:2];
        end
    end

    // ---------------- FIFO, flags, threshold ----------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [8:0]    count_q, thresh_q;
    logic          frame_err_q, overrun_q, par_err_q, irq_q;
    logic          empty, full, rd, pop, ctrl_wr, clr, flush;
    logic          do_push, do_pop, ovr_set;

    assign empty   = (count_q == 9'd0);
    assign full    = (count_q == 9'(DEPTH));
    assign rd      = dp_vld_q & ~dp_wr_q;
    assign pop     = rd & (dp_addr_q == 2'd0) & ~empty;
    assign ctrl_wr = dp_vld_q & dp_wr_q & (dp_addr_q == 2'd2);
    assign clr     = ctrl_wr & HWDATA[31];
    assign flush   = ctrl_wr & HWDATA[30];
    // a simultaneous pop frees the slot, so a full FIFO still accepts the byte
    assign do_push = rx_push & ~flush & (~full | pop);
    assign do_pop  = pop & ~flush;
    assign ovr_set = rx_push & ~flush & full & ~pop;

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wp_q] <= sh_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            thresh_q    <= 9'(THRESH_RST);
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            par_err_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (flush) begin
                wp_q    <= '0;
                rp_q    <= '0;
                count_q <= '0;
            end else begin
                if (do_push) wp_q <= wp_q + 1'b1;
                if (do_pop)  rp_q <= rp_q + 1'b1;
                count_q <= count_q + 9'(do_push) - 9'(do_pop);
            end
            if (ctrl_wr) thresh_q <= HWDATA[8:0];
            // a new error in the same cycle as a clear wins
            frame_err_q <= (frame_err_q & ~clr) | ferr_set;
            overrun_q   <= (overrun_q   & ~clr) | ovr_set;
            par_err_q   <= (par_err_q   & ~clr) | perr_set;
            irq_q       <= (count_q >= thresh_q) & (thresh_q != 9'd0);
        end
    end

    always_comb begin
        HRDATA = '0;
        if (rd) begin
            case (dp_addr_q)
                2'd0: if (!empty) HRDATA = {23'b0, 1'b1, mem[rp_q]};
                2'd1: HRDATA = {15'b0, count_q, 3'b0, par_err_q, overrun_q,
                                frame_err_q, full, empty};
                2'd2: HRDATA = {23'b0, thresh_q};
                default: HRDATA = '0;
            endcase
        end
    end

    assign HREADY      = 1'b1;
    assign IO_WIFI_INT = irq_q;

    logic unused_ok;
    assign unused_ok = ^{HADDR[1:0], HTRANS[0], HWDATA[29:9]};

endmodule

// File: tb/tb_mfp_ahb_wifi_rx.sv
module tb_mfp_ahb_wifi_rx;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int DIV    = CLK_HZ / BAUD;   // 16
`ifdef MFP_WIFI_RX_PARITY_EN
    localparam int NBITS  = 10;              // start + 8 data + parity before stop
`else
    localparam int NBITS  = 9;
`endif
    // edge on which the stop bit is sampled, counted from the start-bit drive
    localparam int PUSH_AT = 3 + DIV / 2 + NBITS * DIV;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        HSEL = 1'b0, HWRITE = 1'b0, WIFI_RX = 1'b1;
    logic [3:0]  HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADY, IO_WIFI_INT;

    int nchk = 0, npass = 0;
    logic [31:0] d;

    mfp_ahb_wifi_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(16), .THRESH_RST(1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .WIFI_RX(WIFI_RX), .IO_WIFI_INT(IO_WIFI_INT)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic ahb_read(input logic [3:0] a, output logic [31:0] r);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        cyc(1);
        HSEL = 1'b0; HTRANS = 2'b00;
        r = HRDATA;
    endtask

    task automatic ahb_write(input logic [3:0] a, input logic [31:0] v);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        cyc(1);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = v;
        cyc(1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        WIFI_RX = 1'b0; cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            WIFI_RX = b[i]; cyc(DIV);
        end
`ifdef MFP_WIFI_RX_PARITY_EN
        WIFI_RX = ^b; cyc(DIV);
`endif
        WIFI_RX = stop; cyc(DIV);
        WIFI_RX = 1'b1; cyc(2);
    endtask

    initial begin
        cyc(3);
        HRESETn = 1'b1;
        cyc(2);

        // reset state
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hready", {31'b0, HREADY}, 32'h1);
        chk("rst_irq", {31'b0, IO_WIFI_INT}, 32'h0);
        ahb_read(4'h4, d); chk("rst_status", d, 32'h0000_0001);
        ahb_read(4'h8, d); chk("rst_ctrl", d, 32'h0000_0001);
        ahb_read(4'h0, d); chk("rst_data_empty", d, 32'h0);
        ahb_read(4'hC, d); chk("rst_reg_c", d, 32'h0);

        // single byte
        send_byte(8'hA5, 1'b1);
        ahb_read(4'h4, d); chk("a5_status", d, 32'h0000_0100);
        chk("a5_irq", {31'b0, IO_WIFI_INT}, 32'h1);
        ahb_read(4'h0, d); chk("a5_data", d, 32'h0000_01A5);
        ahb_read(4'h4, d); chk("a5_status_empty", d, 32'h0000_0001);

        // glitches: 1 cycle, then DIV/4 cycles
        WIFI_RX = 1'b0; cyc(1); WIFI_RX = 1'b1; cyc(2 * DIV);
        WIFI_RX = 1'b0; cyc(DIV / 4); WIFI_RX = 1'b1; cyc(2 * DIV);
        ahb_read(4'h4, d); chk("glitch_status", d, 32'h0000_0001);
        send_byte(8'h55, 1'b1);
        ahb_read(4'h0, d); chk("glitch_then_55", d, 32'h0000_0155);

        // framing error, then clear
        send_byte(8'h3C, 1'b0);
        ahb_read(4'h4, d); chk("ferr_status", d, 32'h0000_0005);
        ahb_write(4'h8, 32'h8000_0001);
        ahb_read(4'h4, d); chk("ferr_cleared", d, 32'h0000_0001);

        // threshold interrupt
        ahb_write(4'h8, 32'h0000_0004);
        ahb_read(4'h8, d); chk("thresh_rb", d, 32'h0000_0004);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
        chk("irq_below", {31'b0, IO_WIFI_INT}, 32'h0);
        send_byte(8'h44, 1'b1);
        chk("irq_at", {31'b0, IO_WIFI_INT}, 32'h1);
        ahb_read(4'h4, d); chk("thresh_status", d, 32'h0000_0400);
        ahb_read(4'h0, d); chk("thresh_pop", d, 32'h0000_0111);
        cyc(1); chk("irq_lag", {31'b0, IO_WIFI_INT}, 32'h1);
        cyc(1); chk("irq_fall", {31'b0, IO_WIFI_INT}, 32'h0);
        ahb_write(4'h8, 32'h4000_0004);
        ahb_read(4'h4, d); chk("flush_status", d, 32'h0000_0001);
        chk("flush_irq", {31'b0, IO_WIFI_INT}, 32'h0);

        // overflow: 17 bytes into 16 entries
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        ahb_read(4'h4, d); chk("ovr_status", d, 32'h0000_100A);
        for (int i = 0; i < 16; i++) begin
            ahb_read(4'h0, d); chk($sformatf("ovr_data%0d", i), d, 32'h100 | i);
        end
        ahb_read(4'h0, d); chk("ovr_data_empty", d, 32'h0);
        ahb_write(4'h8, 32'h8000_0004);
        ahb_read(4'h4, d); chk("ovr_cleared", d, 32'h0000_0001);

        // full FIFO: pop lands on the same edge as a stop-bit push
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1);
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (PUSH_AT - 2) @(posedge HCLK);
                #1;
                ahb_read(4'h0, d);
                chk("coinc_data", d, 32'h0000_0120);
            end
        join
        ahb_read(4'h4, d); chk("coinc_status", d, 32'h0000_1002);

        // reset in the middle of a frame
        WIFI_RX = 1'b0; cyc(50);
        HRESETn = 1'b0; WIFI_RX = 1'b1; cyc(3);
        HRESETn = 1'b1; cyc(2);
        chk("mid_rst_irq", {31'b0, IO_WIFI_INT}, 32'h0);
        ahb_read(4'h4, d); chk("mid_rst_status", d, 32'h0000_0001);
        ahb_read(4'h8, d); chk("mid_rst_ctrl", d, 32'h0000_0001);
        send_byte(8'h5A, 1'b1);
        ahb_read(4'h0, d); chk("post_rst_data", d, 32'h0000_015A);
        ahb_read(4'h4, d); chk("post_rst_status", d, 32'h0000_0001);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
